// File: rtl/mii_frame_generator.sv
// mii_frame_generator
// Emits START / payload / TERM frames separated by programmable idle gaps on an
// NB-lane (8 bits per lane) data+ctrl bus. Payload can be a fixed 8'hAA pattern,
// an incrementing byte index or a PRBS-8 sequence reseeded at every frame.
//
// Handshake: every output is registered. o_valid marks the bus word as
// meaningful; a word is consumed on a rising clk edge where o_valid & i_ready.
// While i_ready is low the bus, state, counters and LFSR all hold. o_valid is
// low only in reset and rises on the first edge after reset release, without
// needing i_ready.
//
// The bus word is produced by one builder shared by all states. It takes a
// starting lane (lane 0 holds START for the first word of a frame), the
// payload bytes still owed, and the payload generator state. It fills payload
// lanes, places TERM in the first free lane after the payload and pads the
// rest with IDLE. If the payload exactly fills the word, no TERM fits. The next
// word is then built with zero payload bytes owed, which yields a TERM-only
// word with TERM in lane 0.
module mii_frame_generator #(
  parameter int          DATA_WIDTH = 64,
  parameter int          CTRL_WIDTH = 8,
  parameter logic [7:0]  IDLE_CODE  = 8'h07,
  parameter logic [7:0]  START_CODE = 8'hFB,
  parameter logic [7:0]  TERM_CODE  = 8'hFD,
  parameter int          LEN_W      = 16,
  parameter int          IPG_W      = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic [LEN_W-1:0]      i_frame_len,
  input  logic [IPG_W-1:0]      i_ipg,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [31:0]           o_frame_cnt,
  output logic [1:0]            o_dbg_state
);

  // CTRL_WIDTH is expected to equal NB (one control bit per lane).
  localparam int NB = DATA_WIDTH / 8;

  // Kind of word currently presented on the bus.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_TERM  = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;        // payload bytes not yet placed on the bus
  logic [7:0]       idx;        // incrementing-mode byte index for the next payload byte
  logic [7:0]       lfsr;       // PRBS state for the next payload byte
  logic [1:0]       mode_l;     // payload mode latched for the current frame
  logic [IPG_W-1:0] ipg_l;      // idle words required before the next START
  logic [IPG_W-1:0] gap_cnt;    // accepted idle words since the last frame
  logic             term_sent;  // current bus word carries TERM

  logic [LEN_W-1:0] len_eff;
  logic [IPG_W-1:0] ipg_eff;
  logic [IPG_W-1:0] gap_inc;
  logic             start_go;

  logic             b_first;
  logic [LEN_W-1:0] b_rem;
  logic [7:0]       b_lfsr;
  logic [7:0]       b_idx;
  logic [1:0]       b_mode;

  logic [DATA_WIDTH-1:0] w_data;
  logic [CTRL_WIDTH-1:0] w_ctrl;
  logic [LEN_W-1:0]      w_used;
  logic [7:0]            w_lfsr;
  logic [7:0]            w_idx;
  logic                  w_term;

  // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    lfsr_next = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Payload byte for a given mode. Mode 3 behaves like mode 0.
  function automatic logic [7:0] payload_byte(input logic [1:0] mode,
                                              input logic [7:0] idx_v,
                                              input logic [7:0] lfsr_v);
    case (mode)
      2'd1:    payload_byte = idx_v;
      2'd2:    payload_byte = lfsr_v;
      default: payload_byte = 8'hAA;
    endcase
  endfunction

  assign o_dbg_state = state;

  // Zero length and zero gap are promoted to one.
  always_comb begin
    len_eff  = (i_frame_len == '0) ? LEN_W'(1) : i_frame_len;
    ipg_eff  = (i_ipg == '0) ? IPG_W'(1) : i_ipg;
    gap_inc  = (&gap_cnt) ? gap_cnt : gap_cnt + 1'b1;
    start_go = (state == S_IDLE) && i_enable && (gap_inc >= ipg_l);
  end

  // Select the builder inputs: fresh frame parameters in IDLE, running state otherwise.
  always_comb begin
    b_first = (state == S_IDLE);
    b_rem   = b_first ? len_eff : rem;
    b_lfsr  = b_first ? LFSR_SEED : lfsr;
    b_idx   = b_first ? 8'd0 : idx;
    b_mode  = b_first ? i_mode : mode_l;
  end

  // Build the next frame word lane by lane: START, payload, one TERM, then IDLE.
  always_comb begin
    w_data = {NB{IDLE_CODE}};
    w_ctrl = '1;
    w_used = '0;
    w_lfsr = b_lfsr;
    w_idx  = b_idx;
    w_term = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k == 0 && b_first) begin
        w_data[7:0] = START_CODE;
      end else if (w_used < b_rem) begin
        w_data[8*k +: 8] = payload_byte(b_mode, w_idx, w_lfsr);
        w_ctrl[k]        = 1'b0;
        w_used           = w_used + 1'b1;
        w_idx            = w_idx + 8'd1;
        w_lfsr           = lfsr_next(w_lfsr);
      end else if (!w_term) begin
        w_data[8*k +: 8] = TERM_CODE;
        w_term           = 1'b1;
      end
    end
  end

  // Frame FSM and all registered outputs; everything advances only on acceptance.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_tx_data   <= {NB{IDLE_CODE}};
      o_tx_ctrl   <= '1;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_cnt <= 32'd0;
      rem         <= '0;
      idx         <= 8'd0;
      lfsr        <= LFSR_SEED;
      mode_l      <= 2'd0;
      ipg_l       <= IPG_W'(1);
      gap_cnt     <= '0;
      term_sent   <= 1'b0;
    end else if (!o_valid) begin
      // First edge after reset: present the idle word as valid.
      o_valid <= 1'b1;
    end else if (i_ready) begin
      case (state)
        S_IDLE: begin
          if (start_go) begin
            mode_l    <= i_mode;
            ipg_l     <= ipg_eff;
            o_tx_data <= w_data;
            o_tx_ctrl <= w_ctrl;
            o_busy    <= 1'b1;
            rem       <= b_rem - w_used;
            lfsr      <= w_lfsr;
            idx       <= w_idx;
            term_sent <= w_term;
            gap_cnt   <= '0;
            state     <= S_START;
          end else begin
            o_tx_data <= {NB{IDLE_CODE}};
            o_tx_ctrl <= '1;
            o_busy    <= 1'b0;
            gap_cnt   <= gap_inc;
          end
        end
        default: begin
          if (term_sent) begin
            // TERM word accepted: frame complete, back to idle.
            o_frame_cnt <= o_frame_cnt + 32'd1;
            o_tx_data   <= {NB{IDLE_CODE}};
            o_tx_ctrl   <= '1;
            o_busy      <= 1'b0;
            term_sent   <= 1'b0;
            gap_cnt     <= '0;
            state       <= S_IDLE;
          end else begin
            o_tx_data <= w_data;
            o_tx_ctrl <= w_ctrl;
            o_busy    <= 1'b1;
            rem       <= b_rem - w_used;
            lfsr      <= w_lfsr;
            idx       <= w_idx;
            term_sent <= w_term;
            state     <= (rem == '0) ? S_TERM : S_DATA;
          end
        end
      endcase
    end
  end

endmodule
